// File: rtl/spike_shift_pkg.sv
// Shared configuration, stage payload type and helpers for the spike shift pipeline.
// SPIKE_SHIFT_DROP_CNT_EN adds a popcount sideband to the payload.
package spike_shift_pkg;

  localparam int unsigned LEN           = 8;
  localparam int unsigned NUM_CH        = 4;
  localparam int unsigned MAX_SHIFT_MAG = 3;

  function automatic int unsigned calc_k(input int unsigned max_mag);
    return $clog2(max_mag + 1);
  endfunction

  function automatic int unsigned calc_shift_w(input int unsigned max_mag);
    return $clog2(max_mag) + 2;
  endfunction

  localparam int unsigned K       = calc_k(MAX_SHIFT_MAG);
  localparam int unsigned SHIFT_W = calc_shift_w(MAX_SHIFT_MAG);
  localparam int unsigned MAG_W   = K;
  localparam int unsigned DATA_W  = NUM_CH * LEN;
  localparam int unsigned POP_W   = $clog2(DATA_W + 1);

  // Payload carried through every pipeline stage; dir=1 means advance (toward lower t).
  typedef struct packed {
    logic [DATA_W-1:0]       data;
    logic [NUM_CH-1:0]       dir;
    logic [NUM_CH*MAG_W-1:0] mag;
    logic                    wrap;
    logic [NUM_CH-1:0]       sat;
`ifdef SPIKE_SHIFT_DROP_CNT_EN
    logic [POP_W-1:0]        pop;
`endif
  } stage_t;

  typedef struct packed {
    logic             dir;
    logic [MAG_W-1:0] mag;
    logic             sat;
  } clamp_t;

  // Split a signed shift into direction and clamped magnitude.
  function automatic clamp_t clamp_shift(input logic [SHIFT_W-1:0] sh);
    clamp_t             r;
    logic [SHIFT_W-1:0] mag_abs;
    r       = '0;
    r.dir   = sh[SHIFT_W-1];
    mag_abs = r.dir ? (~sh + SHIFT_W'(1)) : sh;
    r.sat   = (mag_abs > SHIFT_W'(MAX_SHIFT_MAG));
    r.mag   = r.sat ? MAG_W'(MAX_SHIFT_MAG) : MAG_W'(mag_abs);
    return r;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/spike_shift_stage.sv
// One registered barrel stage: shifts or rotates every channel by 1<<BIT when that
// magnitude bit is set, otherwise passes the payload through.
module spike_shift_stage
  import spike_shift_pkg::*;
#(
  parameter int unsigned BIT = 0
)
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   advance,
  input  logic   src_valid,
  input  stage_t src,
  output logic   dst_valid,
  output stage_t dst
);

  localparam int unsigned DIST = 1 << BIT;

  stage_t nxt;

  always_comb begin
    logic [LEN-1:0] ch;
    logic [LEN-1:0] res;
    nxt = src;
    ch  = '0;
    res = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ch  = src.data[c*LEN +: LEN];
      res = ch;
      if (src.mag[c*MAG_W + BIT]) begin
        // Advance moves spikes toward t=0; delay toward t=LEN-1.
        if (src.dir[c]) begin
          res = src.wrap ? ((ch >> DIST) | (ch << (LEN - DIST))) : (ch >> DIST);
        end else begin
          res = src.wrap ? ((ch << DIST) | (ch >> (LEN - DIST))) : (ch << DIST);
        end
      end
      nxt.data[c*LEN +: LEN] = res;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dst_valid <= 1'b0;
      dst       <= '0;
    end else if (advance) begin
      dst_valid <= src_valid;
      dst       <= nxt;
    end
  end

endmodule

// File: rtl/spike_shift_pipe.sv
// Pipelined multi-channel spike-vector time shifter: clamp stage plus K barrel stages.
// Optional spike-loss counter enabled by SPIKE_SHIFT_DROP_CNT_EN.
module spike_shift_pipe
  import spike_shift_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_CH*LEN-1:0]     in_data,
  input  logic [NUM_CH*SHIFT_W-1:0] in_shift,
  input  logic                      in_wrap,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CH*LEN-1:0]     out_data,
  output logic [NUM_CH-1:0]         out_sat
`ifdef SPIKE_SHIFT_DROP_CNT_EN
  ,
  output logic [15:0]               drop_count
`endif
);

  logic   advance;
  logic   s0_valid;
  stage_t s0_pay;
  stage_t s0_next;
  logic   valid [K+1];
  stage_t pay   [K+1];

  // Whole pipe moves as one; a stalled output freezes every stage.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    clamp_t cl;
    s0_next      = '0;
    cl           = '0;
    s0_next.data = in_data;
    s0_next.wrap = in_wrap;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cl                              = clamp_shift(in_shift[c*SHIFT_W +: SHIFT_W]);
      s0_next.dir[c]                  = cl.dir;
      s0_next.mag[c*MAG_W +: MAG_W]   = cl.mag;
      s0_next.sat[c]                  = cl.sat;
    end
`ifdef SPIKE_SHIFT_DROP_CNT_EN
    s0_next.pop = popcount(in_data);
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s0_valid <= 1'b0;
      s0_pay   <= '0;
    end else if (advance) begin
      s0_valid <= in_valid;
      s0_pay   <= s0_next;
    end
  end

  assign valid[0] = s0_valid;
  assign pay[0]   = s0_pay;

  for (genvar k = 0; k < K; k++) begin : g_stage
    spike_shift_stage #(
      .BIT (k)
    ) u_stage (
      .clock     (clock),
      .reset_n   (reset_n),
      .advance   (advance),
      .src_valid (valid[k]),
      .src       (pay[k]),
      .dst_valid (valid[k+1]),
      .dst       (pay[k+1])
    );
  end

  assign out_valid = valid[K];
  assign out_data  = pay[K].data;
  assign out_sat   = pay[K].sat;

  // Routing fields have no consumer past the last barrel stage.
  logic unused_tail;
  assign unused_tail = ^{pay[K].dir, pay[K].mag, pay[K].wrap};

`ifdef SPIKE_SHIFT_DROP_CNT_EN
  logic [POP_W-1:0] out_pop;
  logic [POP_W-1:0] lost;
  logic [16:0]      cnt_sum;

  always_comb begin
    out_pop = popcount(pay[K].data);
    lost    = pay[K].pop - out_pop;
    cnt_sum = 17'(drop_count) + 17'(lost);
  end

  // Saturating accumulation of spikes pushed off the vector edges.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (out_valid && out_ready) begin
      drop_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_spike_shift_pipe.sv
// Scoreboard bench for spike_shift_pipe: directed vectors, latency, clamp, backpressure, reset.
module tb_spike_shift_pipe;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [15:0] in_shift;
  logic        in_wrap;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_sat;
`ifdef SPIKE_SHIFT_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  spike_shift_pipe dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shift   (in_shift),
    .in_wrap    (in_wrap),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat)
`ifdef SPIKE_SHIFT_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  sat;
    int          drop;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [15:0] sh;
    logic        w;
  } tx_t;

  exp_t sb [$];
  tx_t  pend [$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_drop = 0;
  bit   last_in_ready;
  bit   acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: out bit t = in bit (t-s), wrapped or dropped, with s clamped to +/-3.
  function automatic exp_t model(input logic [31:0] d, input logic [15:0] sh, input logic w);
    exp_t              e;
    logic signed [3:0] f;
    int                s, src, pin, pout;
    e.data = '0; e.sat = '0; pin = 0; pout = 0;
    for (int c = 0; c < 4; c++) begin
      f = sh[c*4 +: 4];
      s = int'(f);
      if (s > 3) begin s = 3; e.sat[c] = 1'b1; end
      else if (s < -3) begin s = -3; e.sat[c] = 1'b1; end
      for (int t = 0; t < 8; t++) begin
        src = t - s;
        if (w) src = (src + 8) % 8;
        if (src >= 0 && src < 8) e.data[c*8 + t] = d[c*8 + src];
      end
    end
    for (int i = 0; i < 32; i++) begin
      pin  += int'(d[i]);
      pout += int'(e.data[i]);
    end
    e.drop = pin - pout;
    return e;
  endfunction

  // One clock: score the output handshake, log the input handshake, check stall hold.
  task automatic tick(output bit accepted);
    bit          con, hold;
    logic [31:0] pd;
    logic [3:0]  ps;
    exp_t        e;
    #1;
    accepted      = in_valid && in_ready;
    con           = out_valid && out_ready;
    hold          = out_valid && !out_ready;
    last_in_ready = in_ready;
    pd = out_data;
    ps = out_sat;
    if (con) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_sat", 32'(out_sat), 32'(e.sat));
        exp_drop += e.drop;
      end
    end
    if (accepted) sb.push_back(model(in_data, in_shift, in_wrap));
    @(posedge clock);
    #1;
    if (hold) begin
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_data", out_data, pd);
      check("hold_sat", 32'(out_sat), 32'(ps));
    end
`ifdef SPIKE_SHIFT_DROP_CNT_EN
    check("drop_count", 32'(drop_count), 32'((exp_drop > 65535) ? 65535 : exp_drop));
`endif
  endtask

  task automatic drive(input logic [31:0] d, input logic [15:0] sh, input logic w);
    in_valid = 1'b1;
    in_data  = d;
    in_shift = sh;
    in_wrap  = w;
  endtask

  task automatic send(input logic [31:0] d, input logic [15:0] sh, input logic w);
    bit got;
    got = 1'b0;
    drive(d, sh, w);
    for (int i = 0; i < 20 && !got; i++) begin
      tick(got);
    end
    if (!got) check("send_timeout", 32'(got), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      tick(acc);
    end
    check("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_wrap = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", out_data, 32'(0));
    check("rst_out_sat", 32'(out_sat), 32'(0));
`ifdef SPIKE_SHIFT_DROP_CNT_EN
    check("rst_drop_count", 32'(drop_count), 32'(0));
`endif
    reset_n   = 1'b1;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    out_ready = 1'b1;

    // Latency: three back-to-back accepts, outputs after the 3rd, 4th and 5th edges.
    drive(32'h0000_0006, 16'h0002, 1'b0);
    tick(acc); check("lat_rdy1", 32'(last_in_ready), 32'(1)); check("lat_ov1", 32'(out_valid), 32'(0));
    drive(32'h0000_0006, 16'h000E, 1'b0);
    tick(acc); check("lat_rdy2", 32'(last_in_ready), 32'(1)); check("lat_ov2", 32'(out_valid), 32'(0));
    drive(32'h0000_C000, 16'h0030, 1'b1);
    tick(acc); check("lat_rdy3", 32'(last_in_ready), 32'(1)); check("lat_ov3", 32'(out_valid), 32'(1));
    in_valid = 1'b0;
    tick(acc); check("lat_ov4", 32'(out_valid), 32'(1));
    tick(acc); check("lat_ov5", 32'(out_valid), 32'(1));
    tick(acc); check("lat_ov6", 32'(out_valid), 32'(0));
    check("lat_sb_empty", 32'(sb.size()), 32'(0));

    // Wrap off, clamp both signs, exact max, zero data, mixed channels.
    send(32'h0000_C000, 16'h0030, 1'b0);
    send(32'h0000_0081, 16'h0005, 1'b0);
    send(32'h00F0_0000, 16'h0800, 1'b0);
    send(32'h00F0_0000, 16'h0800, 1'b1);
    send(32'h0000_0081, 16'h0003, 1'b1);
    send(32'h0000_0081, 16'h000D, 1'b0);
    send(32'h0000_0000, 16'h5B8F, 1'b0);
    send(32'hA5C3_1E81, 16'hD3F1, 1'b0);
    send(32'hA5C3_1E81, 16'h8572, 1'b1);
    drain();

    // Stream with a five-cycle output stall in the middle.
    for (int i = 0; i < 12; i++) begin
      pend.push_back('{d: $urandom, sh: 16'($urandom), w: 1'($urandom_range(0, 1))});
    end
    for (int cyc = 0; cyc < 60 && (pend.size() > 0 || sb.size() > 0); cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 10);
      if (pend.size() > 0) drive(pend[0].d, pend[0].sh, pend[0].w);
      else in_valid = 1'b0;
      tick(acc);
      if (acc) void'(pend.pop_front());
      if (cyc == 7) check("bp_in_ready", 32'(last_in_ready), 32'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_pending", 32'(pend.size()), 32'(0));
    check("bp_sb_empty", 32'(sb.size()), 32'(0));

    // Reset with two transactions in flight: nothing may emerge.
    drive(32'h1234_5678, 16'h1111, 1'b0);
    tick(acc);
    drive(32'h8765_4321, 16'hFFFF, 1'b1);
    tick(acc);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clock);
    #1;
    check("mid_rst_ov", 32'(out_valid), 32'(0));
    sb.delete();
    exp_drop = 0;
    reset_n  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(acc);
      check("post_rst_ov", 32'(out_valid), 32'(0));
    end

    send(32'h0000_0006, 16'h0002, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
